// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two bus-side requesters and alu_arbiter.
// master: requesters and response consumer; slave: the arbiter.
interface alu_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [6:0] req0_op;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [6:0] req1_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter and sequencer in front of the 8-bit ALU datapath.
// Define ALU_ARB_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                on,
    alu_arbiter_if.slave        bus,
    output logic [7:0]          alu_num1,
    output logic [7:0]          alu_num2,
    output logic [6:0]          alu_out_sel,
    output logic [2:0]          alu_in_sel,
    input  logic [7:0]          alu_out,
    output logic [1:0]          curr_state,
    output logic [1:0]          next_state
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StResp  = 2'b11
    } state_e;

    localparam logic [2:0] LatInit = 3'(ALU_LAT);

    state_e     state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [6:0] op_q, op_d;
    logic       id_q, id_d, err_q, err_d;
    logic [2:0] cnt_q, cnt_d;

    logic       req_any, pick1;
    logic       ready0, ready1, rsp_valid;
    logic [7:0] sel_a, sel_b;
    logic [6:0] sel_op;

    // Gated by rst so nothing is granted while held in reset.
    assign req_any = on && rst && (bus.req0_valid || bus.req1_valid);

`ifdef ALU_ARB_PRIO_EN
    assign pick1 = bus.req1_valid && !bus.req0_valid;
`else
    logic last_q, last_d;

    assign pick1 = bus.req1_valid && (!bus.req0_valid || !last_q);

    always_comb begin
        last_d = last_q;
        if (state_q == StIdle && req_any) begin
            last_d = pick1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign sel_a  = pick1 ? bus.req1_a  : bus.req0_a;
    assign sel_b  = pick1 ? bus.req1_b  : bus.req0_b;
    assign sel_op = pick1 ? bus.req1_op : bus.req0_op;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        id_d       = id_q;
        err_d      = err_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        ready0     = 1'b0;
        ready1     = 1'b0;
        rsp_valid  = 1'b0;
        alu_in_sel = 3'b000;
        case (state_q)
            StIdle: begin
                if (req_any) begin
                    ready0 = !pick1;
                    ready1 = pick1;
                    id_d   = pick1;
                    // Bad ops skip the ALU entirely and leave its operands untouched.
                    if ($onehot(sel_op)) begin
                        a_d     = sel_a;
                        b_d     = sel_b;
                        op_d    = sel_op;
                        err_d   = 1'b0;
                        state_d = StIssue;
                    end else begin
                        err_d   = 1'b1;
                        data_d  = 8'h00;
                        state_d = StResp;
                    end
                end
            end
            StIssue: begin
                alu_in_sel = 3'b010;
                cnt_d      = LatInit;
                state_d    = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    data_d  = alu_out;
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            op_q    <= 7'h00;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 8'h00;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            err_q   <= err_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_err    = err_q;
    assign alu_num1       = a_q;
    assign alu_num2       = b_q;
    assign alu_out_sel    = op_q;
    assign curr_state     = state_q;
    assign next_state     = state_d;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a
// transaction-timeline model; honours ALU_ARB_PRIO_EN when defined.
module tb_alu_arbiter;
    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       on  = 1'b0;
    logic [7:0] alu_num1, alu_num2, alu_out;
    logic [6:0] alu_out_sel;
    logic [2:0] alu_in_sel;
    logic [1:0] curr_state, next_state;

    alu_arbiter_if bus ();

    alu_arbiter #(.ALU_LAT(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .on          (on),
        .bus         (bus),
        .alu_num1    (alu_num1),
        .alu_num2    (alu_num2),
        .alu_out_sel (alu_out_sel),
        .alu_in_sel  (alu_in_sel),
        .alu_out     (alu_out),
        .curr_state  (curr_state),
        .next_state  (next_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [6:0] op);
        case (op)
            7'b0000001: alu_fn = a + b;
            7'b0000010: alu_fn = a - b;
            7'b0000100: alu_fn = a & b;
            7'b0001000: alu_fn = a | b;
            7'b0010000: alu_fn = a ^ b;
            7'b0100000: alu_fn = a << 1;
            7'b1000000: alu_fn = ~a;
            default:    alu_fn = 8'h00;
        endcase
    endfunction

    // ALU stand-in: result valid exactly L cycles after the load cycle, inverted before.
    int         alu_cnt;
    logic [7:0] alu_res;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_cnt <= 0;
            alu_res <= 8'h00;
        end else if (alu_in_sel == 3'b010) begin
            alu_cnt <= 1;
            alu_res <= alu_fn(alu_num1, alu_num2, alu_out_sel);
        end else if (alu_cnt != 0 && alu_cnt < L) begin
            alu_cnt <= alu_cnt + 1;
        end
    end
    assign alu_out = (alu_cnt == L) ? alu_res : ~alu_res;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model: an accepted op yields a response L+2 cycles later (1 cycle for a bad op).
    bit         m_busy, m_last, m_err, m_id;
    int         m_wait;
    logic [7:0] m_a, m_b, m_data;
    logic [6:0] m_op;
    bit         g0, g1;
    int         m_hs, dut_hs;

    task automatic model_reset();
        m_busy = 0;
        m_wait = 0;
        m_last = 1;
    endtask

    task automatic step();
        bit exp_rsp;
        #1;
        g0 = 0;
        g1 = 0;
        if (!m_busy && on) begin
`ifdef ALU_ARB_PRIO_EN
            g0 = bus.req0_valid;
`else
            g0 = bus.req0_valid && (!bus.req1_valid || m_last);
`endif
            g1 = bus.req1_valid && !g0;
        end
        exp_rsp = m_busy && m_wait == 0;
        check_eq("req0_ready", 32'(bus.req0_ready), 32'(g0));
        check_eq("req1_ready", 32'(bus.req1_ready), 32'(g1));
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        check_eq("alu_in_sel", 32'(alu_in_sel), (m_busy && m_wait == L + 1) ? 32'h2 : 32'h0);
        check_eq("curr_state", 32'(curr_state),
                 !m_busy ? 0 : (m_wait == L + 1) ? 1 : (m_wait > 0) ? 2 : 3);
        if (exp_rsp) begin
            check_eq("rsp_id", 32'(bus.rsp_id), 32'(m_id));
            check_eq("rsp_data", 32'(bus.rsp_data), 32'(m_data));
            check_eq("rsp_err", 32'(bus.rsp_err), 32'(m_err));
        end
        if (m_busy && !m_err && m_wait > 0) begin
            check_eq("alu_num1", 32'(alu_num1), 32'(m_a));
            check_eq("alu_num2", 32'(alu_num2), 32'(m_b));
            check_eq("alu_out_sel", 32'(alu_out_sel), 32'(m_op));
        end
        if (bus.rsp_valid && bus.rsp_ready) dut_hs++;
        @(posedge clk);
        if (m_busy) begin
            if (m_wait > 0) begin
                m_wait--;
            end else if (bus.rsp_ready) begin
                m_busy = 0;
                m_hs++;
            end
        end else if (g0 || g1) begin
            m_id   = g1;
            m_last = g1;
            m_a    = g1 ? bus.req1_a  : bus.req0_a;
            m_b    = g1 ? bus.req1_b  : bus.req0_b;
            m_op   = g1 ? bus.req1_op : bus.req0_op;
            m_err  = $countones(m_op) != 1;
            m_data = m_err ? 8'h00 : alu_fn(m_a, m_b, m_op);
            m_busy = 1;
            m_wait = m_err ? 0 : L + 1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input int n, input logic [1:0] v, input logic [6:0] op1);
        bus.req0_valid = v[0];
        bus.req1_valid = v[1];
        bus.req1_op    = op1;
        repeat (n) step();
    endtask

    initial begin
        model_reset();
        m_hs = 0;
        dut_hs = 0;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        bus.req0_a  = 8'h57;
        bus.req0_b  = 8'h1A;
        bus.req0_op = 7'b0001000;
        bus.req1_a  = 8'h33;
        bus.req1_b  = 8'h0F;
        bus.req1_op = 7'b0000001;
        bus.rsp_ready = 1;
        repeat (2) @(negedge clk);
        check_eq("rst_curr_state", 32'(curr_state), 0);
        check_eq("rst_next_state", 32'(next_state), 0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("rst_alu_in_sel", 32'(alu_in_sel), 0);
        rst = 1;
        on  = 1;
        @(negedge clk);

        // Single op from req0, then contention, then a bad op on req1.
        drive(1, 2'b01, 7'b0000001);
        drive(6, 2'b00, 7'b0000001);
        drive(30, 2'b11, 7'b0000001);
        drive(1, 2'b10, 7'b0000000);
        drive(4, 2'b00, 7'b0000001);

        // Backpressure held for several cycles while in RESP.
        drive(1, 2'b01, 7'b0000001);
        bus.rsp_ready = 0;
        drive(9, 2'b11, 7'b0000001);
        bus.rsp_ready = 1;
        drive(3, 2'b00, 7'b0000001);

        // Enable low blocks grants; dropping it mid-operation still completes.
        on = 0;
        drive(4, 2'b01, 7'b0000001);
        on = 1;
        drive(1, 2'b01, 7'b0000001);
        on = 0;
        drive(7, 2'b00, 7'b0000001);
        on = 1;

        // Asynchronous reset while in WAIT discards the operation.
        drive(1, 2'b01, 7'b0000001);
        drive(2, 2'b00, 7'b0000001);
        rst = 0;
        #1;
        check_eq("rstwait_curr_state", 32'(curr_state), 0);
        check_eq("rstwait_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("rstwait_alu_in_sel", 32'(alu_in_sel), 0);
        model_reset();
        @(negedge clk);
        rst = 1;
        drive(8, 2'b00, 7'b0000001);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            on             = $urandom_range(0, 9) != 0;
            bus.req0_valid = $urandom_range(0, 9) < 6;
            bus.req1_valid = $urandom_range(0, 9) < 6;
            bus.req0_a     = 8'($urandom);
            bus.req0_b     = 8'($urandom);
            bus.req1_a     = 8'($urandom);
            bus.req1_b     = 8'($urandom);
            bus.req0_op    = ($urandom_range(0, 9) == 0) ? 7'($urandom)
                                                          : 7'(32'd1 << $urandom_range(0, 6));
            bus.req1_op    = ($urandom_range(0, 9) == 0) ? 7'($urandom)
                                                          : 7'(32'd1 << $urandom_range(0, 6));
            bus.rsp_ready  = $urandom_range(0, 9) < 7;
            step();
        end
        check_eq("handshake_count", 32'(dut_hs), 32'(m_hs));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
